// File: rtl/prog_loader.sv
// Loadable instruction store: captures a word stream while the core is held in
// reset, then releases the core and serves combinational reads indexed by progCtr.
module prog_loader #(
  parameter int           D        = 12,
  parameter int           W        = 9,
  parameter logic [W-1:0] HALT     = 9'b101111111,
  parameter int           HOLD_CYC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         loadValid,
  input  logic [W-1:0] loadData,
  input  logic         loadLast,
  output logic         loadReady,
  input  logic [D-1:0] progCtr,
  output logic [W-1:0] machineCode,
  output logic         coreReset,
  output logic [D:0]   loadCount,
  output logic         loadError
);

  typedef enum logic [1:0] {LOAD, HOLD, RUN, ERROR} state_t;

  state_t       stateReg, stateNext;
  logic [D-1:0] wrAddrReg, wrAddrNext;
  logic [D:0]   loadCountReg, loadCountNext;
  logic [3:0]   holdCntReg, holdCntNext;
  logic         loadErrorReg, loadErrorNext;
  logic         accept;

  logic [W-1:0] mem [0:(1<<D)-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg     <= LOAD;
      wrAddrReg    <= '0;
      loadCountReg <= '0;
      holdCntReg   <= '0;
      loadErrorReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      wrAddrReg    <= wrAddrNext;
      loadCountReg <= loadCountNext;
      holdCntReg   <= holdCntNext;
      loadErrorReg <= loadErrorNext;
    end
  end

  // Contents survive reset on purpose; reads are made safe by the loadCount guard.
  always_ff @(posedge clk) begin
    if (accept) mem[wrAddrReg] <= loadData;
  end

  always_comb begin
    stateNext     = stateReg;
    wrAddrNext    = wrAddrReg;
    loadCountNext = loadCountReg;
    holdCntNext   = holdCntReg;
    loadErrorNext = loadErrorReg;
    loadReady     = (stateReg == LOAD) && !reset;
    coreReset     = (stateReg != RUN) || reset;
    accept        = loadValid && loadReady;

    case (stateReg)
      LOAD: begin
        if (accept) begin
          wrAddrNext    = wrAddrReg + D'(1);
          loadCountNext = loadCountReg + (D+1)'(1);
          if (loadLast) begin
            stateNext   = HOLD;
            holdCntNext = 4'(HOLD_CYC - 1);
          end else if (wrAddrReg == '1) begin
            stateNext     = ERROR;
            loadErrorNext = 1'b1;
          end
        end
      end
      HOLD: begin
        if (holdCntReg == 4'd0) stateNext = RUN;
        else                    holdCntNext = holdCntReg - 4'd1;
      end
      RUN:     stateNext = RUN;
      default: stateNext = ERROR;
    endcase

    // Only words actually loaded are ever visible to the core.
    machineCode = HALT;
    if (stateReg == RUN && !reset && ({1'b0, progCtr} < loadCountReg))
      machineCode = mem[progCtr];
  end

  assign loadCount = loadCountReg;
  assign loadError = loadErrorReg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-size instance for load/run behaviour
// and a D=4 instance for capacity overflow and exact-fill corners.
module tb_prog_loader;

  localparam logic [8:0] HALTW = 9'h17F;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadValid;
  logic [8:0]  loadData;
  logic        loadLast;
  logic [11:0] progCtr;

  logic        rdy, cr, err;
  logic [8:0]  code;
  logic [12:0] cnt;
  logic        rdy4, cr4, err4;
  logic [8:0]  code4;
  logic [4:0]  cnt4;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .reset(reset), .loadValid(loadValid), .loadData(loadData),
    .loadLast(loadLast), .loadReady(rdy), .progCtr(progCtr), .machineCode(code),
    .coreReset(cr), .loadCount(cnt), .loadError(err)
  );

  prog_loader #(.D(4)) dut4 (
    .clk(clk), .reset(reset), .loadValid(loadValid), .loadData(loadData),
    .loadLast(loadLast), .loadReady(rdy4), .progCtr(progCtr[3:0]), .machineCode(code4),
    .coreReset(cr4), .loadCount(cnt4), .loadError(err4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Asserts reset between edges and checks the asynchronous effect before any edge.
  task automatic applyReset(input string tag);
    loadValid = 1'b0;
    loadLast  = 1'b0;
    reset     = 1'b1;
    #1;
    chk({tag, " rst loadReady"}, rdy, 0);
    chk({tag, " rst coreReset"}, cr, 1);
    chk({tag, " rst loadCount"}, cnt, 0);
    chk({tag, " rst loadError"}, err, 0);
    chk({tag, " rst machineCode"}, code, HALTW);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({tag, " post-rst loadReady"}, rdy, 1);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [8:0]  d;
    logic        l;
    logic [11:0] pc;
    logic        eRdy;
    logic        eCr;
    logic [12:0] eCnt;
    logic [8:0]  eCode;
  } vec_t;

  vec_t tbl [21];

  initial begin
    reset = 1'b1; loadValid = 1'b0; loadData = '0; loadLast = 1'b0; progCtr = '0;

    // Basic load: three words back to back, a word offered in HOLD, reads in RUN.
    tbl[0]  = '{1'b1, 1'b1, 9'h0A5, 1'b0, 12'd0,    1'b1, 1'b1, 13'd0, HALTW};
    tbl[1]  = '{1'b0, 1'b1, 9'h1FF, 1'b0, 12'd0,    1'b1, 1'b1, 13'd1, HALTW};
    tbl[2]  = '{1'b0, 1'b1, 9'h123, 1'b1, 12'd1,    1'b1, 1'b1, 13'd2, HALTW};
    tbl[3]  = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd0,    1'b0, 1'b1, 13'd3, HALTW};
    tbl[4]  = '{1'b0, 1'b1, 9'h0EE, 1'b0, 12'd2,    1'b0, 1'b1, 13'd3, HALTW};
    tbl[5]  = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd0,    1'b0, 1'b0, 13'd3, 9'h0A5};
    tbl[6]  = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd1,    1'b0, 1'b0, 13'd3, 9'h1FF};
    tbl[7]  = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd2,    1'b0, 1'b0, 13'd3, 9'h123};
    tbl[8]  = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd3,    1'b0, 1'b0, 13'd3, HALTW};
    tbl[9]  = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd4095, 1'b0, 1'b0, 13'd3, HALTW};
    // Gapped stream (valid 1,0,0,1,1) then two words offered in HOLD.
    tbl[10] = '{1'b1, 1'b1, 9'h001, 1'b0, 12'd0,    1'b1, 1'b1, 13'd0, HALTW};
    tbl[11] = '{1'b0, 1'b0, 9'h002, 1'b0, 12'd0,    1'b1, 1'b1, 13'd1, HALTW};
    tbl[12] = '{1'b0, 1'b0, 9'h002, 1'b0, 12'd0,    1'b1, 1'b1, 13'd1, HALTW};
    tbl[13] = '{1'b0, 1'b1, 9'h002, 1'b0, 12'd0,    1'b1, 1'b1, 13'd1, HALTW};
    tbl[14] = '{1'b0, 1'b1, 9'h003, 1'b1, 12'd0,    1'b1, 1'b1, 13'd2, HALTW};
    tbl[15] = '{1'b0, 1'b1, 9'h004, 1'b0, 12'd0,    1'b0, 1'b1, 13'd3, HALTW};
    tbl[16] = '{1'b0, 1'b1, 9'h004, 1'b0, 12'd3,    1'b0, 1'b1, 13'd3, HALTW};
    tbl[17] = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd0,    1'b0, 1'b0, 13'd3, 9'h001};
    tbl[18] = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd1,    1'b0, 1'b0, 13'd3, 9'h002};
    tbl[19] = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd2,    1'b0, 1'b0, 13'd3, 9'h003};
    tbl[20] = '{1'b0, 1'b0, 9'h000, 1'b0, 12'd3,    1'b0, 1'b0, 13'd3, HALTW};

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].rst) applyReset($sformatf("vec%0d", i));
      loadValid = tbl[i].v;
      loadData  = tbl[i].d;
      loadLast  = tbl[i].l;
      progCtr   = tbl[i].pc;
      #1;
      chk($sformatf("vec%0d loadReady", i), rdy, tbl[i].eRdy);
      chk($sformatf("vec%0d coreReset", i), cr, tbl[i].eCr);
      chk($sformatf("vec%0d loadCount", i), cnt, tbl[i].eCnt);
      chk($sformatf("vec%0d machineCode", i), code, tbl[i].eCode);
      chk($sformatf("vec%0d loadError", i), err, 0);
      step();
    end

    // Overflow on the D=4 instance: 16 words, no loadLast.
    applyReset("ovf");
    progCtr = 12'd0;
    for (int i = 0; i < 16; i++) begin
      loadValid = 1'b1; loadData = 9'(9'h100 + i); loadLast = 1'b0;
      #1;
      chk($sformatf("ovf w%0d loadReady", i), rdy4, 1);
      step();
    end
    loadData = 9'h0AA;
    #1;
    chk("ovf loadCount", cnt4, 16);
    chk("ovf loadError", err4, 1);
    chk("ovf coreReset", cr4, 1);
    chk("ovf loadReady", rdy4, 0);
    step();
    step();
    chk("ovf 17th loadCount", cnt4, 16);
    chk("ovf sticky loadError", err4, 1);
    chk("ovf sticky coreReset", cr4, 1);
    chk("ovf machineCode", code4, HALTW);
    loadValid = 1'b0;

    // Exact fill on the D=4 instance: last on the 16th word.
    applyReset("fill");
    for (int i = 0; i < 16; i++) begin
      loadValid = 1'b1; loadData = 9'(9'h040 + i); loadLast = (i == 15);
      step();
    end
    loadValid = 1'b0; loadLast = 1'b0; progCtr = 12'd15;
    #1;
    chk("fill loadError", err4, 0);
    chk("fill loadCount", cnt4, 16);
    chk("fill hold coreReset", cr4, 1);
    chk("fill hold machineCode", code4, HALTW);
    step();
    chk("fill hold2 coreReset", cr4, 1);
    step();
    chk("fill run coreReset", cr4, 0);
    chk("fill pc15", code4, 9'h04F);
    progCtr = 12'd0;
    #1;
    chk("fill pc0", code4, 9'h040);

    // Reset mid-load, then a one-word program.
    applyReset("mid0");
    loadValid = 1'b1; loadData = 9'h011; step();
    loadData = 9'h022; step();
    applyReset("mid");
    loadValid = 1'b1; loadData = 9'h055; loadLast = 1'b1;
    step();
    loadValid = 1'b0; loadLast = 1'b0; progCtr = 12'd0;
    #1;
    chk("mid loadCount", cnt, 1);
    step();
    step();
    chk("mid coreReset", cr, 0);
    chk("mid pc0", code, 9'h055);
    progCtr = 12'd1;
    #1;
    chk("mid pc1", code, HALTW);

    // Reset while running: coreReset and HALT must appear without an edge.
    progCtr = 12'd0;
    #1;
    chk("run pre-rst pc0", code, 9'h055);
    applyReset("inrun");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Loadable instruction store that replaces the fixed instruction ROM in front of the core's fetch/decode path. While the core is held in reset, it accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them to sequential addresses from 0. After the final word it releases the core. It then serves combinational instruction reads indexed by the program counter.

## Interface
Parameters:
- D, 12, program-counter/address width; capacity 2^D words
- W, 9, machine-code word width
- HALT, 9'b101111111, word returned for any address not loaded
- HOLD_CYC, 2, cycles coreReset stays high after the last word is accepted (1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all loader state
- loadValid  in  1  host presents a word
- loadData  in  W  word to store
- loadLast  in  1  qualifies loadData as the final word; sampled only on acceptance
- loadReady  out  1  loader can accept a word this cycle
- progCtr  in  D  core fetch address
- machineCode  out  W  instruction at progCtr (combinational)
- coreReset  out  1  reset to the core and its PC; high until the program is loaded and released
- loadCount  out  D+1  number of words accepted since reset
- loadError  out  1  capacity overflow; sticky until reset

## Operation
- States: LOAD, HOLD, RUN, ERROR. Reset puts the block in LOAD and clears wrAddr, loadCount, the hold counter, and loadError.
- **LOAD:**
  - loadReady = 1, except 0 while reset is high.
  - Accept = loadValid & loadReady.
  - On accept: mem[wrAddr] <= loadData; wrAddr and loadCount increment.
  - Accept with loadLast=1 goes to HOLD; the hold counter loads HOLD_CYC-1.
  - Accept with loadLast=0 at wrAddr = 2^D-1 stores the word, sets loadCount = 2^D, then goes to ERROR.
  - Accept with loadLast=1 at wrAddr = 2^D-1 is legal and goes to HOLD.
- **HOLD:**
  - loadReady = 0; loadValid is ignored.
  - The counter decrements each cycle and goes to RUN when it is 0.
- **RUN:**
  - loadReady = 0; coreReset = 0.
  - Stays in RUN until reset. Reloading requires reset.
- **ERROR:** loadReady = 0, loadError = 1, coreReset = 1. Stays in ERROR until reset.
- **coreReset:** 1 in LOAD, HOLD, and ERROR, and while reset is high; 0 only in RUN.
- **machineCode:**
  - In RUN: mem[progCtr] if progCtr < loadCount (unsigned, D+1-bit compare); otherwise HALT.
  - Outside RUN: always HALT, so the core's done detection cannot fire on stale data.
- Memory array is not cleared by reset. Deterministic reads come only from the loadCount guard.
- **Zero-length program is not possible:** the first accepted word always counts, even if it carries loadLast.

## Timing
- **Reset values:** loadReady 0 during reset, 1 after release; coreReset 1; loadCount 0; loadError 0; machineCode HALT.
- **Write latency:** a word accepted at edge k is readable from edge k (visible in RUN only).
- **Release latency:**
  - Last word accepted at edge k: HOLD from k.
  - With HOLD_CYC = 2, coreReset falls after edge k+2, i.e. RUN from k+2.
- **Throughput:** one word per cycle with loadValid held high.
- **Reset mid-load:** asynchronous return to LOAD.
  - loadCount = 0 immediately, so prior contents read as HALT.
  - The host must restart the stream at word 0.
- **Reset in RUN:** coreReset rises asynchronously with reset. machineCode = HALT immediately.
- **progCtr changes:** machineCode follows combinationally, with no added cycle.

## Test plan
- **Basic load:** reset, stream 0x0A5, 0x1FF, 0x123 (last on 3rd) back-to-back → loadCount 3; coreReset falls 2 cycles after 3rd accept; in RUN, progCtr 0/1/2 → 0x0A5/0x1FF/0x123; progCtr 3 → 0x17F (HALT).
- **Backpressure/gaps:** loadValid toggled 1,0,0,1,1 with words 0x001, 0x002, 0x003 (last) → exactly 3 writes; loadReady 0 in HOLD; a 4th word presented in HOLD is not stored and loadCount stays 3.
- **Overflow:** D=4, stream 16 words with no loadLast → loadCount 16, loadError 1, coreReset stays 1, loadReady 0; a 17th valid word is ignored.
- **Exact fill:** D=4, 16 words, last on 16th → no error; RUN; progCtr 15 → 16th word.
- **Reset mid-load:** load 2 words, assert reset between edges → loadCount 0 and loadReady 0 without waiting for an edge; reload one word 0x055 (last) → progCtr 0 → 0x055, progCtr 1 → HALT.
- **Pre-RUN read:** during LOAD and HOLD, any progCtr → machineCode HALT.
